food_spawner: RTL and testbench

- Consumer of the free-running `random` number streams for the snake game.
- On a spawn request it samples a random candidate cell and range-checks it against the grid.
- It reads the board occupancy memory and retries until it finds an empty cell or exhausts its try budget.
- It publishes the chosen food coordinate with a one-cycle valid strobe to the game controller.

---
 rtl/food_spawner.sv | 173 +++++++++++++++++
 tb/tb_food_spawner.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/food_spawner.sv
// -----------------------------------------------------------------------------
// food_spawner
//
// Picks a new food cell for the snake game. On a spawn request it samples the
// free-running random streams, rejects candidates that fall outside the grid,
// looks the remaining candidates up in the board occupancy memory and retries
// until it finds an empty cell or runs out of tries.
//
// Ports
//   clock      : system clock, everything on posedge
//   resetn     : synchronous active-low reset
//   spawn_req  : request a new food position (only honoured while idle)
//   rand_x     : random x source (8 bits)
//   rand_y     : random y source (7 bits)
//   occ_rd_en  : occupancy read strobe (high for the single READ cycle)
//   occ_x      : occupancy read address x (also the latched candidate x)
//   occ_y      : occupancy read address y (also the latched candidate y)
//   occ_data   : occupancy bit, valid the cycle after occ_rd_en (1 = blocked)
//   food_x     : current food x
//   food_y     : current food y
//   food_valid : one-cycle strobe, food_x/food_y just updated
//   fail       : one-cycle strobe, try budget exhausted, food unchanged
//   busy       : high whenever a spawn is in progress
// -----------------------------------------------------------------------------
module food_spawner #(
    parameter int GRID_W    = 160,
    parameter int GRID_H    = 120,
    parameter int MAX_TRIES = 255
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       spawn_req,
    input  logic [7:0] rand_x,
    input  logic [6:0] rand_y,
    output logic       occ_rd_en,
    output logic [7:0] occ_x,
    output logic [6:0] occ_y,
    input  logic       occ_data,
    output logic [7:0] food_x,
    output logic [6:0] food_y,
    output logic       food_valid,
    output logic       fail,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SAMPLE = 2'd1,
        S_READ   = 2'd2,
        S_CHECK  = 2'd3
    } state_t;

    // One extra bit so a grid of the full coordinate range still compares
    localparam logic [8:0] LP_GRID_W    = 9'(GRID_W);
    localparam logic [7:0] LP_GRID_H    = 8'(GRID_H);
    localparam logic [7:0] LP_MAX_TRIES = 8'(MAX_TRIES);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_tries;
    logic [7:0] w_tries_next;
    logic [7:0] r_occ_x;
    logic [7:0] w_occ_x_next;
    logic [6:0] r_occ_y;
    logic [6:0] w_occ_y_next;
    logic [7:0] r_food_x;
    logic [7:0] w_food_x_next;
    logic [6:0] r_food_y;
    logic [6:0] w_food_y_next;
    logic       r_food_valid;
    logic       w_food_valid_next;
    logic       r_fail;
    logic       w_fail_next;

    logic       w_in_range;
    logic       w_reject;
    logic [7:0] w_tries_inc;

    assign w_in_range  = ({1'b0, rand_x} < LP_GRID_W) && ({1'b0, rand_y} < LP_GRID_H);
    assign w_tries_inc = r_tries + 8'd1;

    always_comb begin
        w_state_next      = r_state;
        w_tries_next      = r_tries;
        w_occ_x_next      = r_occ_x;
        w_occ_y_next      = r_occ_y;
        w_food_x_next     = r_food_x;
        w_food_y_next     = r_food_y;
        w_food_valid_next = 1'b0;
        w_fail_next       = 1'b0;
        w_reject          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (spawn_req) begin
                    w_state_next = S_SAMPLE;
                    w_tries_next = 8'd0;
                end
            end
            S_SAMPLE: begin
                // Candidate is latched even when out of range; the read
                // address simply is not used in that case.
                w_occ_x_next = rand_x;
                w_occ_y_next = rand_y;
                if (w_in_range) begin
                    w_state_next = S_READ;
                end else begin
                    w_reject = 1'b1;
                end
            end
            S_READ: begin
                w_state_next = S_CHECK;
            end
            S_CHECK: begin
                if (!occ_data) begin
                    w_food_x_next     = r_occ_x;
                    w_food_y_next     = r_occ_y;
                    w_food_valid_next = 1'b1;
                    w_state_next      = S_IDLE;
                end else begin
                    w_reject = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Shared rejection path for out-of-range and occupied candidates.
        // tries never exceeds MAX_TRIES, so the 8-bit count cannot wrap.
        if (w_reject) begin
            w_tries_next = w_tries_inc;
            if (w_tries_inc == LP_MAX_TRIES) begin
                w_fail_next  = 1'b1;
                w_state_next = S_IDLE;
            end else begin
                w_state_next = S_SAMPLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_tries      <= 8'd0;
            r_occ_x      <= 8'd0;
            r_occ_y      <= 7'd0;
            r_food_x     <= 8'd0;
            r_food_y     <= 7'd0;
            r_food_valid <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_tries      <= w_tries_next;
            r_occ_x      <= w_occ_x_next;
            r_occ_y      <= w_occ_y_next;
            r_food_x     <= w_food_x_next;
            r_food_y     <= w_food_y_next;
            r_food_valid <= w_food_valid_next;
            r_fail       <= w_fail_next;
        end
    end

    assign occ_rd_en  = (r_state == S_READ);
    assign busy       = (r_state != S_IDLE);
    assign occ_x      = r_occ_x;
    assign occ_y      = r_occ_y;
    assign food_x     = r_food_x;
    assign food_y     = r_food_y;
    assign food_valid = r_food_valid;
    assign fail       = r_fail;

endmodule

// File: tb/tb_food_spawner.sv
module tb_food_spawner;

    logic       clock = 1'b0;
    logic       resetn;
    logic       spawn_req;
    logic [7:0] rand_x;
    logic [6:0] rand_y;
    logic       occ_rd_en;
    logic [7:0] occ_x;
    logic [6:0] occ_y;
    logic       occ_data;
    logic [7:0] food_x;
    logic [6:0] food_y;
    logic       food_valid;
    logic       fail;
    logic       busy;

    food_spawner #(
        .GRID_W   (160),
        .GRID_H   (120),
        .MAX_TRIES(4)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .spawn_req (spawn_req),
        .rand_x    (rand_x),
        .rand_y    (rand_y),
        .occ_rd_en (occ_rd_en),
        .occ_x     (occ_x),
        .occ_y     (occ_y),
        .occ_data  (occ_data),
        .food_x    (food_x),
        .food_y    (food_y),
        .food_valid(food_valid),
        .fail      (fail),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Board model: either everything blocked, or a single blocked cell.
    logic       occ_all;
    logic [7:0] occ_ox;
    logic [6:0] occ_oy;
    always @(posedge clock) begin
        occ_data <= occ_rd_en && (occ_all || (occ_x == occ_ox && occ_y == occ_oy));
    end

    int edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit         is_fail;
        logic [7:0] x;
        logic [6:0] y;
        int         k;
        int         lat;
        int         reads;
        int         rd_base;
    } exp_t;

    exp_t exp_q[$];

    int         rd_cnt = 0;
    logic [7:0] last_rd_x = 8'd0;
    logic [6:0] last_rd_y = 7'd0;
    logic       prev_strobe = 1'b0;

    // Output monitor: pops an expected record for every strobe.
    always @(negedge clock) begin
        if (occ_rd_en === 1'b1) begin
            rd_cnt    <= rd_cnt + 1;
            last_rd_x <= occ_x;
            last_rd_y <= occ_y;
        end
        if (food_valid === 1'b1 || fail === 1'b1) begin
            check("strobe_exclusive", {31'd0, food_valid & fail}, 32'd0);
            check("strobe_one_cycle", {31'd0, prev_strobe}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                exp_t r;
                r = exp_q.pop_front();
                check("fail", {31'd0, fail}, {31'd0, r.is_fail});
                check("food_valid", {31'd0, food_valid}, {31'd0, !r.is_fail});
                check("food_x", {24'd0, food_x}, {24'd0, r.x});
                check("food_y", {25'd0, food_y}, {25'd0, r.y});
                check("latency", edge_cnt - r.k, r.lat);
                check("reads", rd_cnt - r.rd_base, r.reads);
                check("busy_at_strobe", {31'd0, busy}, 32'd0);
                if (!r.is_fail) begin
                    check("last_read_x", {24'd0, last_rd_x}, {24'd0, r.x});
                    check("last_read_y", {25'd0, last_rd_y}, {25'd0, r.y});
                end
                $display("txn k=%0d fail=%0b food=(%0d,%0d) lat=%0d reads=%0d",
                         r.k, fail, food_x, food_y, edge_cnt - r.k, rd_cnt - r.rd_base);
            end
        end
        prev_strobe <= (food_valid === 1'b1) || (fail === 1'b1);
    end

    typedef struct {
        logic [7:0] rx0;
        logic [6:0] ry0;
        logic [7:0] rx1;
        logic [6:0] ry1;
        logic       all;
        logic [7:0] ox;
        logic [6:0] oy;
        bit         is_fail;
        logic [7:0] ex;
        logic [6:0] ey;
        int         lat;
        int         reads;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] model_fx = 8'd0;
    logic [6:0] model_fy = 7'd0;

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("strobe_timeout", 32'd1, 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t r;
        @(negedge clock);
        rand_x    = v.rx0;
        rand_y    = v.ry0;
        occ_all   = v.all;
        occ_ox    = v.ox;
        occ_oy    = v.oy;
        spawn_req = 1'b1;
        if (!v.is_fail) begin
            model_fx = v.ex;
            model_fy = v.ey;
        end
        r.is_fail = v.is_fail;
        r.x       = model_fx;
        r.y       = model_fy;
        r.k       = edge_cnt + 1;
        r.lat     = v.lat;
        r.reads   = v.reads;
        r.rd_base = rd_cnt;
        exp_q.push_back(r);
        @(negedge clock);
        spawn_req = 1'b0;
        // Second candidate is presented after the first SAMPLE edge.
        @(posedge clock);
        #1;
        rand_x = v.rx1;
        rand_y = v.ry1;
        wait_done();
        repeat (2) @(negedge clock);
    endtask

    initial begin
        // rx0 ry0  rx1 ry1  all  ox  oy  fail  ex  ey  lat reads
        vecs[0] = '{8'd160, 7'd119, 8'd159, 7'd119, 1'b0, 8'd255, 7'd127, 1'b0, 8'd159, 7'd119, 4, 1};
        vecs[1] = '{8'd10,  7'd120, 8'd0,   7'd0,   1'b0, 8'd255, 7'd127, 1'b0, 8'd0,   7'd0,   4, 1};
        vecs[2] = '{8'd159, 7'd119, 8'd159, 7'd119, 1'b0, 8'd255, 7'd127, 1'b0, 8'd159, 7'd119, 3, 1};
        vecs[3] = '{8'd37,  7'd50,  8'd10,  7'd20,  1'b0, 8'd37,  7'd50,  1'b0, 8'd10,  7'd20,  6, 2};
        vecs[4] = '{8'd37,  7'd50,  8'd37,  7'd50,  1'b0, 8'd255, 7'd127, 1'b0, 8'd37,  7'd50,  3, 1};
        vecs[5] = '{8'd37,  7'd50,  8'd37,  7'd50,  1'b1, 8'd0,   7'd0,   1'b1, 8'd0,   7'd0,  12, 4};
        vecs[6] = '{8'd200, 7'd5,   8'd200, 7'd5,   1'b1, 8'd0,   7'd0,   1'b1, 8'd0,   7'd0,   4, 0};

        resetn    = 1'b0;
        spawn_req = 1'b1;
        rand_x    = 8'd0;
        rand_y    = 7'd0;
        occ_all   = 1'b0;
        occ_ox    = 8'd255;
        occ_oy    = 7'd127;

        // Reset held with spawn_req high: reset wins.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_food_x", {24'd0, food_x}, 32'd0);
        check("rst_food_y", {25'd0, food_y}, 32'd0);
        check("rst_food_valid", {31'd0, food_valid}, 32'd0);
        check("rst_fail", {31'd0, fail}, 32'd0);
        check("rst_occ_rd_en", {31'd0, occ_rd_en}, 32'd0);
        check("rst_occ_x", {24'd0, occ_x}, 32'd0);
        check("rst_occ_y", {25'd0, occ_y}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        resetn    = 1'b1;
        spawn_req = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("idle_after_reset", {31'd0, busy}, 32'd0);
        end

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
            check("busy_after", {31'd0, busy}, 32'd0);
        end

        // Second spawn_req during READ is ignored: exactly one strobe.
        begin
            exp_t r;
            int   n;
            @(negedge clock);
            rand_x    = 8'd33;
            rand_y    = 7'd44;
            occ_all   = 1'b0;
            occ_ox    = 8'd255;
            occ_oy    = 7'd127;
            spawn_req = 1'b1;
            model_fx  = 8'd33;
            model_fy  = 7'd44;
            r = '{1'b0, 8'd33, 7'd44, edge_cnt + 1, 3, 1, rd_cnt};
            exp_q.push_back(r);
            @(negedge clock);
            spawn_req = 1'b0;
            n = 0;
            while (occ_rd_en !== 1'b1 && n < 10) begin
                @(negedge clock);
                n++;
            end
            check("busy_test_read_seen", {31'd0, occ_rd_en}, 32'd1);
            spawn_req = 1'b1;
            @(negedge clock);
            spawn_req = 1'b0;
            wait_done();
            repeat (10) @(negedge clock);
            check("busy_test_idle", {31'd0, busy}, 32'd0);
        end

        // Reset during CHECK: no strobe, food cleared.
        begin
            int n;
            @(negedge clock);
            rand_x    = 8'd70;
            rand_y    = 7'd80;
            spawn_req = 1'b1;
            @(negedge clock);
            spawn_req = 1'b0;
            n = 0;
            while (occ_rd_en !== 1'b1 && n < 10) begin
                @(negedge clock);
                n++;
            end
            @(negedge clock);
            resetn = 1'b0;
            @(negedge clock);
            check("rst_check_food_valid", {31'd0, food_valid}, 32'd0);
            check("rst_check_fail", {31'd0, fail}, 32'd0);
            check("rst_check_food_x", {24'd0, food_x}, 32'd0);
            check("rst_check_food_y", {25'd0, food_y}, 32'd0);
            check("rst_check_busy", {31'd0, busy}, 32'd0);
            resetn = 1'b1;
            repeat (6) @(negedge clock);
            check("rst_check_still_idle", {31'd0, busy}, 32'd0);
            check("rst_check_no_late_strobe", {31'd0, food_valid | fail}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
